// File: rtl/lzw_code_packer_if.sv
// Code-in / packed-word-out bundle between the LZW core, the packer and the file sink.
// master = core + sink side, slave = packer.
interface lzw_code_packer_if #(
  parameter int HASH_WIDTH = 12,
  parameter int OUT_WIDTH  = 8
);
  logic [HASH_WIDTH-1:0] code_in;
  logic                  code_valid;
  logic                  code_ready;
  logic                  flush;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush_done;

  modport master (
    output code_in, code_valid, flush, out_ready,
    input  code_ready, out_data, out_valid, flush_done
  );

  modport slave (
    input  code_in, code_valid, flush, out_ready,
    output code_ready, out_data, out_valid, flush_done
  );
endinterface

// File: rtl/lzw_code_packer.sv
// Packs HASH_WIDTH-bit LZW codes LSB-first into OUT_WIDTH-bit words; zero-pads on flush.
// Optional LZW_PACKER_EOS_EN: append an all-ones end-of-stream code before padding.
//
// state | meaning
// RUN   | accepting codes, emitting full words
// FLUSH | draining full words, then the zero-padded tail word
// DONE  | one-cycle flush_done pulse, then back to RUN
module lzw_code_packer #(
  parameter int HASH_WIDTH = 12,
  parameter int OUT_WIDTH  = 8,
  parameter int ACC_WIDTH  = HASH_WIDTH + OUT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  lzw_code_packer_if.slave  bus
);
  localparam int CW = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc, acc_nxt;
  logic [CW-1:0]          bit_cnt, cnt_nxt;
  logic [OUT_WIDTH-1:0]   od, od_nxt;
  logic                   ov, ov_nxt;
  logic                   have_word, out_free, accept;
`ifdef LZW_PACKER_EOS_EN
  logic                   eos_done, eos_nxt;
  localparam logic [ACC_WIDTH-1:0] EOS_CODE = {{OUT_WIDTH{1'b0}}, {HASH_WIDTH{1'b1}}};
`endif

  assign have_word      = bit_cnt >= CW'(OUT_WIDTH);
  assign out_free       = !ov || bus.out_ready;
  assign bus.code_ready = (state == RUN) && !have_word;
  assign accept         = bus.code_valid && bus.code_ready;
  assign bus.out_data   = od;
  assign bus.out_valid  = ov;
  assign bus.flush_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      acc     <= '0;
      bit_cnt <= '0;
      od      <= '0;
      ov      <= 1'b0;
`ifdef LZW_PACKER_EOS_EN
      eos_done <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      bit_cnt <= cnt_nxt;
      od      <= od_nxt;
      ov      <= ov_nxt;
`ifdef LZW_PACKER_EOS_EN
      eos_done <= eos_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = bit_cnt;
    od_nxt    = od;
    ov_nxt    = ov;
`ifdef LZW_PACKER_EOS_EN
    eos_nxt   = eos_done;
`endif
    if (ov && bus.out_ready) ov_nxt = 1'b0;

    case (state)
      RUN: begin
        if (accept) begin
          acc_nxt = acc | (ACC_WIDTH'(bus.code_in) << bit_cnt);
          cnt_nxt = bit_cnt + CW'(HASH_WIDTH);
        end else if (have_word && out_free) begin
          od_nxt  = acc[OUT_WIDTH-1:0];
          ov_nxt  = 1'b1;
          acc_nxt = acc >> OUT_WIDTH;
          cnt_nxt = bit_cnt - CW'(OUT_WIDTH);
        end
        if (bus.flush) begin
          state_nxt = FLUSH;
`ifdef LZW_PACKER_EOS_EN
          eos_nxt   = 1'b0;
`endif
        end
      end
      FLUSH: begin
        if (have_word && out_free) begin
          od_nxt  = acc[OUT_WIDTH-1:0];
          ov_nxt  = 1'b1;
          acc_nxt = acc >> OUT_WIDTH;
          cnt_nxt = bit_cnt - CW'(OUT_WIDTH);
        end
`ifdef LZW_PACKER_EOS_EN
        else if (!eos_done) begin
          acc_nxt = acc | (EOS_CODE << bit_cnt);
          cnt_nxt = bit_cnt + CW'(HASH_WIDTH);
          eos_nxt = 1'b1;
        end
`endif
        // bits above bit_cnt are always zero, so the low slice is already padded
        else if (bit_cnt != '0 && out_free) begin
          od_nxt  = acc[OUT_WIDTH-1:0];
          ov_nxt  = 1'b1;
          acc_nxt = '0;
          cnt_nxt = '0;
        end else if (bit_cnt == '0 && out_free) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = RUN;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end
      default: state_nxt = RUN;
    endcase
  end
endmodule
